// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the round-robin / manual stream multiplexer.
package stream_mux_rr_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Ceiling log2, used to size channel index fields at elaboration time.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Rotate-priority picker: first asserted req at or after ptr, wrapping at N.
module rr_pick
  import stream_mux_rr_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int unsigned k;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!gnt_any && req[k]) begin
        gnt_idx = SELW'(k);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer, manual select or round-robin arbitration.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_next;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_any;
  logic [SELW-1:0]  cand;
  logic             cand_any;
  logic             sel_ok;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] cand_data;

  rr_pick #(.N(N), .SELW(SELW)) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Out-of-range sel is only possible when N is not a power of two.
  if ((32'd1 << SELW) == N) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = (32'(sel) < N);
  end

  always_comb begin
    cand     = '0;
    cand_any = 1'b0;
    if (mode == MODE_RR) begin
      cand     = gnt_idx;
      cand_any = gnt_any;
    end else begin
      cand     = sel;
      cand_any = sel_ok;
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = (cand_any && load_en) ? (N'(1) << cand) : '0;
  assign xfer     = |(in_valid & in_ready);
  assign ptr_next = (32'(cand) == N - 1) ? '0 : SELW'(cand + SELW'(1));

  always_comb begin
    cand_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(cand) == k) cand_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cand_data;
      out_ch    <= cand;
      if (mode == MODE_RR) ptr <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshaking on every input and on the output. It selects either a software-chosen channel (manual mode) or the next requesting channel in round-robin order (arbitrated mode). It merges coin, keypad and service-port event streams into the single event queue feeding the vending controller FSM.

## Interface
- WIDTH, 8: payload width per channel.
- N, 4: number of input channels, 2..16.
- SELW, $clog2(N): width of channel index fields.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- in_valid  in  N  per-channel data valid.
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept, combinational, at most one bit high.
- mode  in  1  0 = manual (use sel), 1 = round-robin.
- sel  in  SELW  channel index used in manual mode.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered payload.
- out_ch  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  downstream accept.

## Operation
- load_en = !out_valid || out_ready. An output slot is free this cycle when load_en is 1.
- Manual mode:
  - cand = sel.
  - If sel >= N (non-power-of-2 N), no candidate exists and all in_ready are 0.
- Round-robin mode:
  - Internal pointer ptr (SELW bits) marks the highest-priority channel.
  - cand = first k with in_valid[k] high, searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
  - If no channel is valid, there is no candidate.
- in_ready[cand] = load_en. All other in_ready bits are 0. in_ready never depends on in_valid of the same channel in manual mode.
- A transfer occurs when in_valid[cand] && in_ready[cand]. On a transfer:
  - out_data <= that channel's slice.
  - out_ch <= cand.
  - out_valid <= 1.
- If out_ready && out_valid and there is no transfer in the same cycle, out_valid <= 0.
- Round-robin pointer update: ptr <= cand+1 only on a transfer in RR mode. It wraps from N-1 to 0.
- Manual mode leaves ptr unchanged. Switching mode does not reset ptr.
- Output stability: while out_valid && !out_ready, out_data and out_ch hold stable, and all in_ready bits are 0.
- mode and sel are sampled combinationally every cycle. A change takes effect in the same cycle and never corrupts a beat already held in the output register.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready follows from out_valid=0: in manual mode in_ready[sel]=1 (if sel < N); in RR mode it depends on in_valid.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle when out_ready is held at 1 (pop and load in the same cycle).
- Simultaneous pop and load: the output register is overwritten with the new beat and out_valid stays 1.
- rst_n asserted mid-stream: the held beat is dropped and all registers return to their reset values immediately. The first transfer can occur in the first cycle after rst_n deasserts.
- Fairness: with all N channels continuously valid and out_ready=1, the grant sequence in RR mode is 0,1,...,N-1,0,... starting from ptr.

## Structure
- Shared package holds the MODE_MANUAL=1'b0 / MODE_RR=1'b1 constants and the clog2 helper for SELW.
- Natural sub-module: rr_pick, a combinational N-bit rotate-priority picker. Inputs: req, ptr. Outputs: gnt_idx, gnt_any.
- The top level owns the output register, ptr and the handshake logic.

## Test plan
- Reset, N=4, mode=0, sel=2, in_valid=4'b0100, in_data ch2=0xA5, out_ready=1. Required: in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5, out_ch=2.
- Manual backpressure: out_ready=0 with one beat held, ch2 still valid with 0x3C. Required: in_ready=0, out_data stays 0xA5. With out_ready=1: 0x3C appears one cycle later.
- RR fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles. Required: out_ch sequence 0,1,2,3,0,1,2,3 and one beat per cycle.
- RR skip and wrap: ptr=3, in_valid=4'b0010. Required: grant ch1, then ptr=2. Next, with in_valid=4'b1001: grant ch3, then ptr wraps to 0.
- N=3 with sel=3 in manual mode. Required: in_ready=3'b000 and no output beat.
- rst_n pulse low while out_valid=1, asynchronous and between clock edges. Required: out_valid, out_data, out_ch and ptr all 0 immediately.
